// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8N1 serial byte transmitter with registered outputs.
// tx_done_tick serves two purposes. It is the completion pulse at the end of
// each frame, and it is a "ready" heartbeat every CLKS_PER_BIT cycles while
// the transmitter is idle. An initiator that waits for tx_done_tick before
// it issues tx_start therefore never stalls.
module uart_byte_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       top_clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_bus,
  output logic       tx,
  output logic       tx_done_tick,
  output logic       tx_busy
);

  // Last count value of one bit period. The same value serves as the heartbeat period.
  localparam logic [15:0] LP_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t      r_state,   w_state_nxt;
  logic [15:0] r_bit_cnt, w_bit_cnt_nxt;  // cycles spent in current bit
  logic [2:0]  r_bit_idx, w_bit_idx_nxt;  // data bit being sent
  logic [7:0]  r_shift,   w_shift_nxt;    // latched byte, LSB goes out first
  logic [15:0] r_hb_cnt,  w_hb_cnt_nxt;   // idle heartbeat timer
  logic        r_tx,      w_tx_nxt;
  logic        r_done,    w_done_nxt;
  logic        r_busy,    w_busy_nxt;

  logic        w_bit_end;
  logic        w_hb_end;

  assign w_bit_end = (r_bit_cnt == LP_LAST);
  assign w_hb_end  = (r_hb_cnt  == LP_LAST);

  assign tx           = r_tx;
  assign tx_done_tick = r_done;
  assign tx_busy      = r_busy;

  // State and output registers. Reset aborts any frame and returns the line to idle-high.
  always_ff @(posedge top_clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_hb_cnt  <= '0;
      r_tx      <= 1'b1;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_hb_cnt  <= w_hb_cnt_nxt;
      r_tx      <= w_tx_nxt;
      r_done    <= w_done_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  // Next-state logic. Each output is computed for the next cycle so that it leaves a flop directly.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_hb_cnt_nxt  = r_hb_cnt;
    w_tx_nxt      = r_tx;
    w_done_nxt    = 1'b0;
    w_busy_nxt    = r_busy;

    unique case (r_state)
      IDLE: begin
        w_tx_nxt   = 1'b1;
        w_busy_nxt = 1'b0;
        if (tx_start) begin
          // Accepting a request takes priority over a heartbeat due in the same cycle.
          w_state_nxt   = START;
          w_shift_nxt   = tx_bus;
          w_bit_cnt_nxt = '0;
          w_bit_idx_nxt = '0;
          w_hb_cnt_nxt  = '0;
          w_tx_nxt      = 1'b0;
          w_busy_nxt    = 1'b1;
        end else if (w_hb_end) begin
          w_hb_cnt_nxt = '0;
          w_done_nxt   = 1'b1;
        end else begin
          w_hb_cnt_nxt = r_hb_cnt + 16'd1;
        end
      end

      START: begin
        if (w_bit_end) begin
          w_bit_cnt_nxt = '0;
          w_state_nxt   = DATA;
          w_tx_nxt      = r_shift[0];
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 16'd1;
        end
      end

      DATA: begin
        if (w_bit_end) begin
          w_bit_cnt_nxt = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            // Shift toward the LSB. The bit shown next is the current bit 1.
            w_bit_idx_nxt = r_bit_idx + 3'd1;
            w_shift_nxt   = {1'b0, r_shift[7:1]};
            w_tx_nxt      = r_shift[1];
          end
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 16'd1;
        end
      end

      STOP: begin
        if (w_bit_end) begin
          // The completion pulse lands in the first IDLE cycle and restarts the heartbeat.
          w_bit_cnt_nxt = '0;
          w_bit_idx_nxt = '0;
          w_state_nxt   = IDLE;
          w_tx_nxt      = 1'b1;
          w_busy_nxt    = 1'b0;
          w_done_nxt    = 1'b1;
          w_hb_cnt_nxt  = '0;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 16'd1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_byte_tx.sv
// tb_uart_byte_tx: scoreboard bench for uart_byte_tx with CLKS_PER_BIT=4.
// The stimulus pushes expected frames (byte, first low cycle, length) and
// expected tx_done_tick cycles. The negedge monitor decodes the serial line
// and the pulses, and compares each one against the queue heads.
module tb_uart_byte_tx;

  localparam int CPB = 4;

  typedef struct {
    logic [7:0] b;
    int         start;
    int         len;    // 40 for a full frame, fewer when a reset aborts it
  } frame_t;

  logic       top_clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_bus = 8'h00;
  logic       tx;
  logic       tx_done_tick;
  logic       tx_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  frame_t fq[$];
  int     dq[$];

  uart_byte_tx #(.CLKS_PER_BIT(CPB)) dut (
    .top_clk      (top_clk),
    .rst          (rst),
    .tx_start     (tx_start),
    .tx_bus       (tx_bus),
    .tx           (tx),
    .tx_done_tick (tx_done_tick),
    .tx_busy      (tx_busy)
  );

  initial forever #5 top_clk = ~top_clk;

  // cyc counts rising edges. A negedge sample taken after edge k sees cyc == k.
  always @(posedge top_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge top_clk);
  endtask

  task automatic push_frame(input logic [7:0] b, input int start, input int len);
    frame_t f;
    f.b = b; f.start = start; f.len = len;
    fq.push_back(f);
  endtask

  // Monitor: serial decoder plus pulse checker.
  initial begin
    frame_t     cur;
    bit         active = 0;
    int         pos = 0;
    int         skip = 0;
    int         bp;
    logic       lvl;
    logic [7:0] rx = 8'h00;
    logic       prev_done = 1'b0;
    forever begin
      @(negedge top_clk);
      if (cyc >= 1) begin
        // Pulse checks
        if (tx_done_tick === 1'b1) begin
          if (dq.size() == 0) begin
            checks++; errors++;
            $display("FAIL done_unexpected: pulse at cycle %0d, none required", cyc);
          end else begin
            chk("done_cycle", cyc, dq.pop_front());
          end
          chk("done_while_busy", tx_busy, 1'b0);
          chk("done_consecutive", prev_done, 1'b0);
        end
        prev_done = tx_done_tick;

        // Serial line decoding
        if (skip > 0) begin
          skip--;
        end else begin
          if (!active && tx === 1'b0) begin
            if (fq.size() == 0) begin
              checks++; errors++;
              $display("FAIL frame_unexpected: tx low at cycle %0d, no frame required", cyc);
              skip = 10 * CPB - 1;
            end else begin
              cur = fq.pop_front();
              chk("frame_start", cyc, cur.start);
              active = 1; pos = 0; rx = 8'h00;
            end
          end
          if (active) begin
            bp = pos / CPB;
            if (bp == 0)      lvl = 1'b0;
            else if (bp <= 8) lvl = cur.b[bp-1];
            else              lvl = 1'b1;
            chk("tx_level", tx, lvl);
            chk("busy_in_frame", tx_busy, 1'b1);
            if ((pos % CPB) == CPB / 2 && bp >= 1 && bp <= 8) rx[bp-1] = tx;
            pos++;
            if (pos == cur.len) begin
              active = 0;
              if (cur.len == 10 * CPB) chk("rx_byte", rx, cur.b);
            end
          end else if (skip == 0 && tx === 1'b1) begin
            chk("busy_idle", tx_busy, 1'b0);
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    int budget;
    // Reset held for edges 1..3, released in the low phase after edge 3
    wait_cyc(3);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_done", tx_done_tick, 1'b0);
    rst = 1'b0;
    dq.push_back(7); dq.push_back(11); dq.push_back(15);

    // 0xA5 accepted at edge 18, after which tx_bus is scrambled
    wait_cyc(17);
    push_frame(8'hA5, 18, 40);
    dq.push_back(58);
    dq.push_back(62);
    tx_start = 1'b1; tx_bus = 8'hA5;
    wait_cyc(18);
    tx_start = 1'b0;
    wait_cyc(20);
    tx_bus = 8'h00;

    // 0xA5 accepted in the heartbeat cycle at 62. A request for 0xFF during data bit 3 is ignored.
    wait_cyc(62);
    push_frame(8'hA5, 63, 40);
    dq.push_back(103);
    tx_start = 1'b1; tx_bus = 8'hA5;
    wait_cyc(63);
    tx_start = 1'b0;
    wait_cyc(80);
    tx_start = 1'b1; tx_bus = 8'hFF;
    wait_cyc(81);
    tx_start = 1'b0;

    // 0x3C accepted in the completion cycle of the previous frame, which gives a 5-cycle stop period
    wait_cyc(103);
    push_frame(8'h3C, 104, 40);
    dq.push_back(144);
    tx_start = 1'b1; tx_bus = 8'h3C;
    wait_cyc(104);
    tx_start = 1'b0;

    // 0x5A aborted by reset during data bit 2. The line shows 14 low-line-frame samples and then idle.
    wait_cyc(146);
    push_frame(8'h5A, 147, 14);
    tx_start = 1'b1; tx_bus = 8'h5A;
    wait_cyc(147);
    tx_start = 1'b0;
    wait_cyc(160);
    rst = 1'b1;
    wait_cyc(161);
    chk("abort_tx", tx, 1'b1);
    chk("abort_busy", tx_busy, 1'b0);
    chk("abort_done", tx_done_tick, 1'b0);
    wait_cyc(162);
    rst = 1'b0;
    dq.push_back(166);

    // Handshake loop: wait for the pulse, then request the next byte in that same cycle
    for (int i = 0; i < 16; i++) begin
      budget = 0;
      @(negedge top_clk);
      while (tx_done_tick !== 1'b1 && budget < 100) begin
        budget++;
        @(negedge top_clk);
      end
      if (tx_done_tick !== 1'b1) begin
        checks++; errors++;
        $display("FAIL handshake_timeout: no pulse for byte %0d within 100 cycles", i);
        break;
      end
      push_frame(8'(i), 167 + 41 * i, 40);
      dq.push_back(207 + 41 * i);
      tx_start = 1'b1; tx_bus = 8'(i);
      @(negedge top_clk);
      tx_start = 1'b0;
    end
    dq.push_back(826);

    wait_cyc(828);
    chk("frames_left", fq.size(), 0);
    chk("pulses_left", dq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit
  initial begin
    #100000;
    $display("FAIL sim_timeout: cycle %0d reached without finishing", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_byte_tx.md
UART_BYTE_TX -- requirements
Module: uart_byte_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, giving top_clk cycles per serial bit (868 = 115200 baud at 100 MHz); legal range 2..65535.
REQ-002 The block SHALL have port top_clk, input, 1 bit: the only clock; all logic on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port tx_start, input, 1 bit: request to send the byte on tx_bus, sampled every cycle.
REQ-005 The block SHALL have port tx_bus, input, 8 bits: byte to transmit, captured in the cycle tx_start is accepted.
REQ-006 The block SHALL have port tx, output, 1 bit: serial line, registered, idle-high.
REQ-007 The block SHALL have port tx_done_tick, output, 1 bit: one-cycle ready/completion pulse, registered.
REQ-008 The block SHALL have port tx_busy, output, 1 bit: high while a frame is in progress, registered.

Function
REQ-009 Frame format SHALL be 8N1: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each held exactly CLKS_PER_BIT cycles.
REQ-010 The block SHALL implement the states IDLE, START, DATA and STOP, with a 16-bit bit-period counter and a 3-bit data-bit index.
REQ-011 In IDLE, tx_start=1 SHALL be accepted: tx_bus is latched into an internal shift register; the next cycle the state is START, tx=0 and tx_busy=1.
REQ-012 START SHALL advance to DATA after CLKS_PER_BIT cycles; DATA SHALL shift out 8 bits, each for CLKS_PER_BIT cycles, then advance to STOP; STOP SHALL hold tx=1 for CLKS_PER_BIT cycles, then return to IDLE.
REQ-013 tx_done_tick SHALL pulse for exactly one cycle in the first IDLE cycle after STOP completes, 10*CLKS_PER_BIT cycles after tx first goes low; tx_busy SHALL be 0 in that same cycle.
REQ-014 Idle heartbeat: while in IDLE with no frame accepted, tx_done_tick SHALL also pulse once every CLKS_PER_BIT cycles, so an initiator that waits for tx_done_tick before its first tx_start can make progress.
REQ-015 The heartbeat counter SHALL clear on reset release and on each completion pulse; the next heartbeat SHALL occur CLKS_PER_BIT cycles later if still idle.
REQ-016 tx_start asserted while tx_busy=1 SHALL be ignored: it is not queued, and the frame in flight and its latched byte are unaffected.
REQ-017 tx_start asserted in the same cycle as any tx_done_tick pulse SHALL be accepted; tx falls the next cycle, giving a stop period of CLKS_PER_BIT+1 cycles and no lost byte.
REQ-018 Changes on tx_bus after acceptance SHALL NOT affect the frame in flight.
REQ-019 tx_done_tick SHALL never be high in two consecutive cycles, and SHALL never be high while tx_busy=1.

Reset
REQ-020 While rst=1 at a clock edge, the next-cycle outputs SHALL be tx=1, tx_done_tick=0, tx_busy=0; the state SHALL be IDLE and all counters 0.
REQ-021 A reset in the middle of a frame SHALL abort the frame: tx returns to 1 the next cycle, and no completion pulse is issued for the aborted byte.
REQ-022 The first heartbeat after reset SHALL occur CLKS_PER_BIT cycles after the first cycle with rst=0.

Verification (CLKS_PER_BIT=4)
REQ-023 Reset then idle, tx_start=0 -> tx=1 and tx_busy=0 throughout; tx_done_tick pulses at cycles 4, 8 and 12 after reset release.
REQ-024 tx_start with tx_bus=0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each level 4 cycles; single tx_done_tick 40 cycles after the falling edge.
REQ-025 During the 0xA5 frame, tx_start with tx_bus=0xFF at bit 3 -> waveform identical to the previous scenario; no second frame follows.
REQ-026 0x3C accepted in the 0xA5 completion-pulse cycle -> 0x3C start bit begins one cycle later; stop period 5 cycles; two completion pulses total.
REQ-027 rst=1 during data bit 2 of 0x5A -> tx=1 and tx_busy=0 next cycle; no completion pulse; heartbeat resumes 4 cycles after release.
REQ-028 Handshake loop (wait for tx_done_tick, then pulse tx_start, 16 bytes 0x00..0x0F) -> all 16 bytes decoded correctly by a bench UART receiver, in order, none dropped.
